// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and helpers for the raster timing generator:
//   - default 640x480@60 porch/sync/active figures (pixels and lines)
//   - sync polarity constants
//   - total-period helpers used for elaboration-time range checks
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis (horizontal or vertical): a wrapping position counter with
// registered blank and sync flags computed from the count being loaded, so the
// flags always describe the same position as o_cnt.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (count 0, blank 0, sync idle)
//   i_step   advance one position this cycle
//   o_cnt    current position, 0..TOTAL-1 (registered)
//   o_blank  position >= ACTIVE (registered)
//   o_sync   sync level, POL when asserted (registered)
//   o_wrap   combinational: this step takes the count from TOTAL-1 back to 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = SYNC_ACTIVE_LOW,
  parameter int CW     = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_step,
  output logic [CW-1:0] o_cnt,
  output logic          o_blank,
  output logic          o_sync,
  output logic          o_wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam bit IDLE  = (POL == SYNC_ACTIVE_HIGH) ? SYNC_ACTIVE_LOW : SYNC_ACTIVE_HIGH;

  localparam logic [CW-1:0] LAST        = CW'(TOTAL - 1);
  // One extra bit so ACTIVE+FP+SYNC == 2**CW (zero back porch) cannot alias to 0.
  localparam logic [CW:0]   BLANK_START = (CW+1)'(ACTIVE);
  localparam logic [CW:0]   SYNC_START  = (CW+1)'(ACTIVE + FP);
  localparam logic [CW:0]   SYNC_END    = (CW+1)'(ACTIVE + FP + SYNC);

  logic [CW-1:0] r_cnt;
  logic          r_blank;
  logic          r_sync;
  logic [CW-1:0] w_next;
  logic          w_wrap;
  logic          w_in_sync;

  assign w_wrap = i_step && (r_cnt == LAST);

  always_comb begin
    w_next = r_cnt;
    if (i_step) begin
      w_next = w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  assign w_in_sync = ({1'b0, w_next} >= SYNC_START) && ({1'b0, w_next} < SYNC_END);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_blank <= 1'b0;
      r_sync  <= IDLE;
    end else begin
      r_cnt   <= w_next;
      r_blank <= ({1'b0, w_next} >= BLANK_START);
      r_sync  <= w_in_sync ? POL : IDLE;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_blank = r_blank;
  assign o_sync  = r_sync;
  assign o_wrap  = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised raster timing generator in a single clock domain with a pixel
// clock-enable. All outputs are registered and describe the same pixel as
// o_x/o_y. Optional test pattern output enabled by macro VGA_TIMING_PATTERN_EN.
// Ports:
//   i_clk, i_rst (sync, active-high, overrides i_ce), i_ce (pixel enable)
//   o_hsync/o_vsync   sync levels per HS_POL/VS_POL
//   o_hblank/o_vblank outside the visible region per axis
//   o_active          visible pixel
//   o_x/o_y           raster position (full raster)
//   o_line_start      one-cycle pulse after an enabled step into x=0
//   o_frame_start     one-cycle pulse after an enabled step into (0,0)
//   o_frame_cnt       frames completed, wrapping
//   o_rgb             8-bar test pattern with white border (macro only)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = SYNC_ACTIVE_LOW,
  parameter bit VS_POL   = SYNC_ACTIVE_LOW,
  parameter int CW       = 12,
  parameter int FCW      = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_ce,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_hblank,
  output logic           o_vblank,
  output logic           o_active,
  output logic [CW-1:0]  o_x,
  output logic [CW-1:0]  o_y,
  output logic           o_line_start,
  output logic           o_frame_start,
  output logic [FCW-1:0] o_frame_cnt
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [2:0]     o_rgb
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (1 << CW)) begin : g_h_total_err
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (1 << CW)) begin : g_v_total_err
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  logic           w_h_wrap;
  logic           w_v_wrap;
  logic           w_v_step;
  logic           r_line_start;
  logic           r_frame_start;
  logic [FCW-1:0] r_frame_cnt;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h_axis (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_step (i_ce),
    .o_cnt  (o_x),
    .o_blank(o_hblank),
    .o_sync (o_hsync),
    .o_wrap (w_h_wrap)
  );

  // Vertical advances only on the horizontal wrap, so vsync moves with x=0.
  assign w_v_step = i_ce & w_h_wrap;

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v_axis (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_step (w_v_step),
    .o_cnt  (o_y),
    .o_blank(o_vblank),
    .o_sync (o_vsync),
    .o_wrap (w_v_wrap)
  );

  // w_v_wrap already implies an enabled horizontal wrap, i.e. a step into (0,0).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
      if (w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + FCW'(1);
      end
    end
  end

  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_active      = ~o_hblank & ~o_vblank;

`ifdef VGA_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BPW   = $clog2(BAR_W + 1);
  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

  if (H_ACTIVE % 8 != 0) begin : g_bar_err
    $error("vga_timing_gen: H_ACTIVE must be a multiple of 8 for the bar pattern");
  end

  logic [BPW-1:0] r_bar_pos;
  logic [2:0]     r_bar_idx;
  logic [2:0]     r_rgb;
  logic [BPW-1:0] w_bar_pos_nxt;
  logic [2:0]     w_bar_idx_nxt;
  logic [CW-1:0]  w_x_nxt;
  logic [CW-1:0]  w_y_nxt;
  logic [2:0]     w_rgb_nxt;

  // Bar position/index track x without a divider; past the active region the
  // index is meaningless and is cleared again on the line wrap.
  always_comb begin
    w_x_nxt       = o_x;
    w_y_nxt       = o_y;
    w_bar_pos_nxt = r_bar_pos;
    w_bar_idx_nxt = r_bar_idx;
    if (w_h_wrap) begin
      w_x_nxt       = '0;
      w_bar_pos_nxt = '0;
      w_bar_idx_nxt = '0;
      w_y_nxt       = w_v_wrap ? '0 : o_y + CW'(1);
    end else if (i_ce) begin
      w_x_nxt = o_x + CW'(1);
      if (r_bar_pos == BAR_LAST) begin
        w_bar_pos_nxt = '0;
        w_bar_idx_nxt = r_bar_idx + 3'd1;
      end else begin
        w_bar_pos_nxt = r_bar_pos + BPW'(1);
      end
    end

    w_rgb_nxt = 3'b000;
    if ((int'(w_x_nxt) < H_ACTIVE) && (int'(w_y_nxt) < V_ACTIVE)) begin
      if ((w_x_nxt == '0) || (int'(w_x_nxt) == H_ACTIVE - 1) ||
          (w_y_nxt == '0) || (int'(w_y_nxt) == V_ACTIVE - 1)) begin
        w_rgb_nxt = 3'b111;
      end else begin
        w_rgb_nxt = ~w_bar_idx_nxt;  // 7 - index
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bar_pos <= '0;
      r_bar_idx <= '0;
      r_rgb     <= 3'b111;
    end else begin
      r_bar_pos <= w_bar_pos_nxt;
      r_bar_idx <= w_bar_idx_nxt;
      r_rgb     <= w_rgb_nxt;
    end
  end

  assign o_rgb = r_rgb;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default 640x480 instance and one tiny raster
// (H 8/1/2/1, V 4/1/1/1, active-high syncs) share the same i_ce/i_rst stimulus.
// The reference model is a single count of enabled steps since reset; every
// expected output follows from that count by division and modulo.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst = 1'b1;
  logic i_ce  = 1'b0;

  logic        a_hsync, a_vsync, a_hblank, a_vblank, a_active, a_ls, a_fs;
  logic [11:0] a_x, a_y;
  logic [15:0] a_fc;
  logic        b_hsync, b_vsync, b_hblank, b_vblank, b_active, b_ls, b_fs;
  logic [11:0] b_x, b_y;
  logic [15:0] b_fc;
`ifdef VGA_TIMING_PATTERN_EN
  logic [2:0]  a_rgb, b_rgb;
`endif

  vga_timing_gen dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_ce(i_ce),
    .o_hsync(a_hsync), .o_vsync(a_vsync), .o_hblank(a_hblank), .o_vblank(a_vblank),
    .o_active(a_active), .o_x(a_x), .o_y(a_y), .o_line_start(a_ls),
    .o_frame_start(a_fs), .o_frame_cnt(a_fc)
`ifdef VGA_TIMING_PATTERN_EN
    , .o_rgb(a_rgb)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_ce(i_ce),
    .o_hsync(b_hsync), .o_vsync(b_vsync), .o_hblank(b_hblank), .o_vblank(b_vblank),
    .o_active(b_active), .o_x(b_x), .o_y(b_y), .o_line_start(b_ls),
    .o_frame_start(b_fs), .o_frame_cnt(b_fc)
`ifdef VGA_TIMING_PATTERN_EN
    , .o_rgb(b_rgb)
`endif
  );

  int     n_vec = 0;
  int     n_err = 0;
  longint p     = 0;     // enabled steps since the last reset
  bit     adv   = 1'b0;  // the last edge was an enabled step
  bit     chk_en = 1'b0;

  always @(posedge clk) begin
    if (i_rst) begin
      p      <= 0;
      adv    <= 1'b0;
      chk_en <= 1'b1;
    end else if (i_ce) begin
      p   <= p + 1;
      adv <= 1'b1;
    end else begin
      adv <= 1'b0;
    end
  end

  task automatic cmp_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %b want %b (step %0d)", name, act, exp, p);
    end
  endtask

  task automatic cmp_n(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d want %0d (step %0d)", name, act, exp, p);
    end
  endtask

  task automatic check_dut(input string tag,
                           input int ha, input int hfp, input int hs, input int hbp,
                           input int va, input int vfp, input int vs, input int vbp,
                           input bit hp, input bit vp,
                           input logic [11:0] x, input logic [11:0] y,
                           input logic hsy, input logic vsy, input logic hb, input logic vb,
                           input logic act, input logic ls, input logic fs,
                           input logic [15:0] fc);
    int ht, vt, eh, ev, ef;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    eh = int'(p % longint'(ht));
    ev = int'((p / longint'(ht)) % longint'(vt));
    ef = int'((p / longint'(ht * vt)) % 65536);
    cmp_n({tag, ".x"}, 32'(x), 32'(eh));
    cmp_n({tag, ".y"}, 32'(y), 32'(ev));
    cmp_b({tag, ".hsync"}, hsy, (eh >= ha + hfp && eh < ha + hfp + hs) ? hp : !hp);
    cmp_b({tag, ".vsync"}, vsy, (ev >= va + vfp && ev < va + vfp + vs) ? vp : !vp);
    cmp_b({tag, ".hblank"}, hb, eh >= ha);
    cmp_b({tag, ".vblank"}, vb, ev >= va);
    cmp_b({tag, ".active"}, act, (eh < ha) && (ev < va));
    cmp_b({tag, ".line_start"}, ls, adv && (eh == 0));
    cmp_b({tag, ".frame_start"}, fs, adv && (eh == 0) && (ev == 0));
    cmp_n({tag, ".frame_cnt"}, 32'(fc), 32'(ef));
  endtask

`ifdef VGA_TIMING_PATTERN_EN
  function automatic logic [2:0] model_rgb(input int ha, input int va, input int ht, input int vt);
    int eh, ev;
    eh = int'(p % longint'(ht));
    ev = int'((p / longint'(ht)) % longint'(vt));
    if (eh >= ha || ev >= va) return 3'b000;
    if (eh == 0 || eh == ha - 1 || ev == 0 || ev == va - 1) return 3'b111;
    return 3'(7 - eh / (ha / 8));
  endfunction
`endif

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut("A", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                a_x, a_y, a_hsync, a_vsync, a_hblank, a_vblank, a_active, a_ls, a_fs, a_fc);
      check_dut("B", 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1,
                b_x, b_y, b_hsync, b_vsync, b_hblank, b_vblank, b_active, b_ls, b_fs, b_fc);
`ifdef VGA_TIMING_PATTERN_EN
      cmp_n("A.rgb", 32'(a_rgb), 32'(model_rgb(640, 480, 800, 525)));
      cmp_n("B.rgb", 32'(b_rgb), 32'(model_rgb(8, 4, 12, 7)));
`endif
    end
  end

  task automatic tick(input bit c, input bit r);
    i_ce  = c;
    i_rst = r;
    @(negedge clk);
  endtask

  initial begin
    int cnt_low, cnt_blank, first_low, last_low, cnt_ls, cnt_fs;

    i_rst = 1'b1;
    i_ce  = 1'b0;
    repeat (3) @(negedge clk);

    cmp_n("rst.A.x", 32'(a_x), 0);
    cmp_n("rst.A.y", 32'(a_y), 0);
    cmp_b("rst.A.hsync", a_hsync, 1'b1);
    cmp_b("rst.A.vsync", a_vsync, 1'b1);
    cmp_b("rst.A.active", a_active, 1'b1);
    cmp_b("rst.A.hblank", a_hblank, 1'b0);
    cmp_b("rst.A.line_start", a_ls, 1'b0);
    cmp_n("rst.A.frame_cnt", 32'(a_fc), 0);
    cmp_b("rst.B.hsync", b_hsync, 1'b0);
    cmp_b("rst.B.vsync", b_vsync, 1'b0);
`ifdef VGA_TIMING_PATTERN_EN
    cmp_n("rst.A.rgb", 32'(a_rgb), 7);
`endif

    // One full default line with i_ce held high.
    cnt_low = 0; cnt_blank = 0; first_low = -1; last_low = -1;
    for (int i = 1; i <= 800; i++) begin
      tick(1'b1, 1'b0);
      if (a_hsync == 1'b0) begin
        cnt_low++;
        if (first_low < 0) first_low = int'(a_x);
        last_low = int'(a_x);
      end
      if (a_hblank) cnt_blank++;
      if (i == 8)  cmp_b("B.hsync@x8", b_hsync, 1'b0);
      if (i == 9) begin
        cmp_n("B.x@9", 32'(b_x), 9);
        cmp_b("B.hsync@x9", b_hsync, 1'b1);
      end
      if (i == 11) cmp_b("B.hsync@x11", b_hsync, 1'b0);
      if (i == 59) cmp_b("B.vsync@y4", b_vsync, 1'b0);
      if (i == 60) begin
        cmp_n("B.y@60", 32'(b_y), 5);
        cmp_b("B.vsync@y5", b_vsync, 1'b1);
        cmp_b("B.line_start@60", b_ls, 1'b1);
      end
      if (i == 83) cmp_b("B.frame_start@83", b_fs, 1'b0);
      if (i == 84) begin
        cmp_b("B.frame_start@84", b_fs, 1'b1);
        cmp_n("B.frame_cnt@84", 32'(b_fc), 1);
        cmp_n("B.x@84", 32'(b_x), 0);
        cmp_n("B.y@84", 32'(b_y), 0);
      end
    end
    cmp_n("A.hsync_low_clks", 32'(cnt_low), 96);
    cmp_n("A.hsync_first_x", 32'(first_low), 656);
    cmp_n("A.hsync_last_x", 32'(last_low), 751);
    cmp_n("A.hblank_clks", 32'(cnt_blank), 160);
    cmp_b("A.line_start@800", a_ls, 1'b1);
    cmp_n("A.y@800", 32'(a_y), 1);
    cmp_n("B.frame_cnt@800", 32'(b_fc), 9);
    cmp_n("B.x@800", 32'(b_x), 8);
    cmp_n("B.y@800", 32'(b_y), 3);

    // Half-rate pixel enable: one line now spans 1600 clocks.
    cnt_low = 0; cnt_ls = 0;
    for (int i = 0; i < 1600; i++) begin
      tick((i % 2) == 0, 1'b0);
      if (a_hsync == 1'b0) cnt_low++;
      if (a_ls) cnt_ls++;
`ifdef VGA_TIMING_PATTERN_EN
      if (a_x == 12'd40)  cmp_n("A.rgb@40", 32'(a_rgb), 7);
      if (a_x == 12'd80)  cmp_n("A.rgb@80", 32'(a_rgb), 6);
      if (a_x == 12'd600) cmp_n("A.rgb@600", 32'(a_rgb), 0);
      if (a_x == 12'd700) cmp_n("A.rgb@700", 32'(a_rgb), 0);
`endif
    end
    cmp_n("A.hsync_low_clks_half", 32'(cnt_low), 192);
    cmp_n("A.line_start_clks_half", 32'(cnt_ls), 1);
    cmp_n("A.x@1600", 32'(a_x), 0);
    cmp_n("A.y@1600", 32'(a_y), 2);

    // Two more tiny-raster frame boundaries (steps 1680 and 1764).
    cnt_fs = 0;
    for (int i = 0; i < 168; i++) begin
      tick(1'b1, 1'b0);
      if (b_fs) cnt_fs++;
    end
    cmp_n("B.frame_starts", 32'(cnt_fs), 2);
    cmp_n("B.frame_cnt@1768", 32'(b_fc), 21);

    // Walk A to x=300 on line 2, then reset with i_ce still high.
    for (int i = 0; i < 132; i++) tick(1'b1, 1'b0);
    cmp_n("A.x@1900", 32'(a_x), 300);
    tick(1'b1, 1'b1);
    cmp_n("mid_rst.A.x", 32'(a_x), 0);
    cmp_n("mid_rst.A.y", 32'(a_y), 0);
    cmp_b("mid_rst.A.active", a_active, 1'b1);
    cmp_b("mid_rst.A.hsync", a_hsync, 1'b1);
    cmp_n("mid_rst.A.frame_cnt", 32'(a_fc), 0);
    cmp_b("mid_rst.A.frame_start", a_fs, 1'b0);
    cmp_n("mid_rst.B.frame_cnt", 32'(b_fc), 0);

    // Irregular enable after reset; first frame of B must not pulse at (0,0).
    for (int i = 0; i < 300; i++) tick((i % 3) != 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
